// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
//   Shared types and constants for the audio DAC path.
//   - dac_state_t : frame serializer FSM states
//   - FRAME_BITS  : width of one serial DAC frame (control byte + sample)
//   - SAMPLE_BITS : width of one audio sample
//   - make_frame  : assembles the transmitted frame word
// -----------------------------------------------------------------------------
package sound_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } dac_state_t;

    // Control byte occupies the upper half, so it is sent first (MSB first).
    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [7:0]             ctrl,
        input logic [SAMPLE_BITS-1:0] sample
    );
        return {ctrl, sample};
    endfunction

endpackage

// File: rtl/dac_tick_gen.sv
// -----------------------------------------------------------------------------
// dac_tick_gen
//   Free-running phase counter. Emits a one-cycle phase_end_o tick on the last
//   cycle of every CLK_DIV-cycle phase. restart_i forces the counter back to 0
//   so the first phase of a frame launched from idle is a full CLK_DIV long.
//
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     restart_i   in   restart the phase (counter to 0 on the next edge)
//     phase_end_o out  high during the last cycle of each phase
// -----------------------------------------------------------------------------
module dac_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    output logic phase_end_o
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default assignment first, so
        // no path through the block can leave it unassigned and infer a latch.
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its next-state value from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With CLK_DIV=1 the counter sits at 0 and every cycle ends a phase.
    assign phase_end_o = (cnt_q == LAST);

endmodule

// File: rtl/dac_frame_serializer.sv
// -----------------------------------------------------------------------------
// dac_frame_serializer
//   Serial DAC front end. Accepts 8-bit samples on a single-cycle write strobe,
//   buffers one pending sample, and shifts each sample out as a 16-bit frame
//   {CTRL_BYTE, sample}, MSB first, on dac_clk/dac_sync/dac_data.
//   Frame = SETUP(1 phase) + SHIFT(32 phases) + HOLD(1) + GAP(1) = 35*CLK_DIV.
//
//   Parameters:
//     CLK_DIV    system clocks per dac_clk half-period (>= 1)
//     CTRL_BYTE  control byte sent in frame bits 15..8
//   Ports:
//     clk       in   system clock
//     rst_n     in   asynchronous active-low reset
//     data      in   sample, sampled only when write=1
//     write     in   single-cycle sample strobe
//     dac_clk   out  serial clock, low when idle; DAC samples on rising edge
//     dac_sync  out  frame sync, active low, high when idle
//     dac_data  out  serial data, MSB first, changes at low-phase start only
//     busy      out  high while a frame or its gap is in progress
//     overrun   out  one-cycle pulse when a pending sample is overwritten
// -----------------------------------------------------------------------------
module dac_frame_serializer
    import sound_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] CTRL_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       write,
    output logic       dac_clk,
    output logic       dac_sync,
    output logic       dac_data,
    output logic       busy,
    output logic       overrun
);

    dac_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [SAMPLE_BITS-1:0] pend_data_q, pend_data_d;
    logic                   dclk_q, dclk_d;
    logic                   sync_q, sync_d;
    logic                   ddata_q, ddata_d;
    logic                   busy_q;
    logic                   ovr_q, ovr_d;

    logic                   phase_end;
    logic                   launch_idle;
    logic                   gap_end;
    logic                   take_pending;
    logic                   launch;
    logic [SAMPLE_BITS-1:0] launch_sample;
    logic [FRAME_BITS-1:0]  launch_word;

    // A frame starts either from IDLE on a write, or back-to-back at the end
    // of GAP when a sample is pending or arrives in that very cycle.
    assign launch_idle   = (state_q == IDLE) && write;
    assign gap_end       = (state_q == GAP) && phase_end;
    assign take_pending  = gap_end && pend_valid_q;
    assign launch        = launch_idle || (gap_end && (pend_valid_q || write));
    assign launch_sample = take_pending ? pend_data_q : data;
    assign launch_word   = make_frame(CTRL_BYTE, launch_sample);

    dac_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart_i   (launch_idle),
        .phase_end_o (phase_end)
    );

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        dclk_d       = dclk_q;
        sync_d       = sync_q;
        ddata_d      = ddata_q;
        ovr_d        = 1'b0;

        unique case (state_q)
            IDLE: ;
            SETUP: begin
                // Bit 15 is already on dac_data; the first low phase keeps it.
                if (phase_end) state_d = SHIFT;
            end
            SHIFT: begin
                if (phase_end) begin
                    if (!dclk_q) begin
                        dclk_d = 1'b1;
                    end else begin
                        dclk_d = 1'b0;
                        if (bit_cnt_q == 4'd0) begin
                            state_d = HOLD;
                        end else begin
                            // Next low phase begins: present the next bit.
                            bit_cnt_d = bit_cnt_q - 4'd1;
                            sr_d      = sr_q << 1;
                            ddata_d   = sr_q[FRAME_BITS-2];
                        end
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    sync_d  = 1'b1;
                    ddata_d = 1'b0;
                end
            end
            GAP: begin
                // Overridden below when a next frame launches.
                if (phase_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d   = SETUP;
            sr_d      = launch_word;
            bit_cnt_d = 4'd15;
            dclk_d    = 1'b0;
            sync_d    = 1'b0;
            ddata_d   = launch_word[FRAME_BITS-1];
        end

        if (take_pending) pend_valid_d = 1'b0;

        // Writes outside IDLE go to the pending slot, except a write in the
        // last GAP cycle with nothing pending, which launches directly.
        // Refilling the slot while its old content launches is not an overrun.
        if (write && (state_q != IDLE) && !(gap_end && !pend_valid_q)) begin
            pend_valid_d = 1'b1;
            pend_data_d  = data;
            ovr_d        = pend_valid_q && !gap_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            // NOTE: the pending data register is reset as well; it is a single
            // word, so clearing it costs nothing and keeps reset state defined.
            pend_data_q  <= '0;
            dclk_q       <= 1'b0;
            sync_q       <= 1'b1;
            ddata_q      <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            dclk_q       <= dclk_d;
            sync_q       <= sync_d;
            ddata_q      <= ddata_d;
            busy_q       <= (state_d != IDLE);
            ovr_q        <= ovr_d;
        end
    end

    assign dac_clk  = dclk_q;
    assign dac_sync = sync_q;
    assign dac_data = ddata_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule
